spec_acc_sched: RTL and testbench

- Sequencer for the range-gated FFT power-spectrum accumulation path of the lidar processing chain.
- Each laser trigger starts one or more 1024-point FFT frames, one per range gate.
- It steers the power-spectrum output into the spectral accumulator: overwrite on the first pulse, add on later pulses.
- After the programmed number of pulses it hands the accumulated spectra to readout with a request/acknowledge handshake.

---
 rtl/spec_acc_pkg.sv | 21 ++
 rtl/spec_bin_counter.sv | 39 +++
 rtl/spec_acc_sched.sv | 136 +++++++++++++
 tb/tb_spec_acc_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_acc_pkg.sv
// Shared definitions for the FFT power-spectrum accumulation sequencer.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spec_acc_pkg;

    // Default FFT geometry
    localparam int FFT_LEN_DEF = 1024;
    localparam int IDX_W_DEF   = 10;

    // Bit offsets of the run-config fields within the user control register
    localparam int CFG_ACC_NUM_LSB   = 0;
    localparam int CFG_GATE_LAST_LSB = 16;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_COLLECT   = 3'd2;
    localparam logic [2:0] ST_WAIT_TRIG = 3'd3;
    localparam logic [2:0] ST_DUMP      = 3'd4;

endpackage

// File: rtl/spec_bin_counter.sv
// Bin counter for one FFT frame: counts valid beats, flags the last bin, checks indices.
// Latency: last_beat_o is combinational on the beat; index_err_o is set the cycle after a bad beat.
// Backpressure: none; the counter follows every beat it is given.
module spec_bin_counter #(
    parameter int FFT_LEN = 1024,
    parameter int IDX_W   = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             beat_i,
    input  logic [IDX_W-1:0] index_i,
    output logic             last_beat_o,
    output logic             index_err_o
);

    logic [IDX_W-1:0] bin_cnt;
    logic             index_err;

    assign last_beat_o = beat_i && (bin_cnt == IDX_W'(FFT_LEN - 1));
    assign index_err_o = index_err;

    // Count beats, wrap at the end of the frame, and latch any index mismatch until the next run
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bin_cnt   <= '0;
            index_err <= 1'b0;
        end else if (clr_i) begin
            bin_cnt   <= '0;
            index_err <= 1'b0;
        end else if (beat_i) begin
            bin_cnt <= last_beat_o ? '0 : bin_cnt + 1'b1;
            if (index_i != bin_cnt) begin
                index_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spec_acc_sched.sv
// Sequences range-gated FFT frames into the spectral accumulator and hands results to readout.
// Latency: acc_en_o/acc_clear_o/fft_start_o are combinational; done_o pulses the cycle after dump_ack_i.
// Backpressure: waits on frame_ready_i before each frame and holds dump_req_o until dump_ack_i.
module spec_acc_sched
    import spec_acc_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int GATE_W  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic [CNT_W-1:0]  cfg_acc_num_i,
    input  logic [GATE_W-1:0] cfg_gate_last_i,
    input  logic              frame_ready_i,
    output logic              fft_start_o,
    input  logic              spec_valid_i,
    input  logic [IDX_W-1:0]  spec_index_i,
    output logic              acc_en_o,
    output logic              acc_clear_o,
    output logic [GATE_W-1:0] gate_o,
    output logic              dump_req_o,
    input  logic              dump_ack_i,
    output logic              done_o,
    output logic              busy_o,
    output logic              index_err_o,
    output logic [CNT_W-1:0]  trig_miss_o
);

    logic [2:0]        state;
    logic [CNT_W-1:0]  acc_num;
    logic [GATE_W-1:0] gate_last;
    logic [CNT_W-1:0]  pulse_cnt;
    logic [GATE_W-1:0] gate;
    logic [CNT_W-1:0]  trig_miss;
    logic              done;

    logic run_start;
    logic beat;
    logic last_beat;
    logic trig_missed;

    assign run_start   = (state == ST_IDLE) && trig_i && (cfg_acc_num_i != '0);
    assign beat        = (state == ST_COLLECT) && spec_valid_i;
    // A trigger is only honoured in IDLE (new run) or WAIT_TRIG (next pulse)
    assign trig_missed = trig_i && ((state == ST_START) || (state == ST_COLLECT) || (state == ST_DUMP));

    assign fft_start_o = (state == ST_START) && frame_ready_i;
    assign acc_en_o    = beat;
    assign acc_clear_o = beat && (pulse_cnt == '0);
    assign gate_o      = gate;
    assign dump_req_o  = (state == ST_DUMP);
    assign done_o      = done;
    assign busy_o      = (state != ST_IDLE);
    assign trig_miss_o = trig_miss;

    spec_bin_counter #(
        .FFT_LEN (FFT_LEN),
        .IDX_W   (IDX_W)
    ) u_bin_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (run_start),
        .beat_i      (beat),
        .index_i     (spec_index_i),
        .last_beat_o (last_beat),
        .index_err_o (index_err_o)
    );

    // Run sequencing: pulse/gate stepping, dump handshake and the missed-trigger counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            acc_num   <= '0;
            gate_last <= '0;
            pulse_cnt <= '0;
            gate      <= '0;
            trig_miss <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (trig_missed && (trig_miss != {CNT_W{1'b1}})) begin
                trig_miss <= trig_miss + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (run_start) begin
                        acc_num   <= cfg_acc_num_i;
                        gate_last <= cfg_gate_last_i;
                        pulse_cnt <= '0;
                        gate      <= '0;
                        trig_miss <= '0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (frame_ready_i) begin
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (last_beat) begin
                        if (gate != gate_last) begin
                            gate  <= gate + 1'b1;
                            state <= ST_START;
                        end else if (pulse_cnt == acc_num - CNT_W'(1)) begin
                            gate  <= '0;
                            state <= ST_DUMP;
                        end else begin
                            gate      <= '0;
                            pulse_cnt <= pulse_cnt + 1'b1;
                            state     <= ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_i) begin
                        state <= ST_START;
                    end
                end
                ST_DUMP: begin
                    if (dump_ack_i) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spec_acc_sched.sv
// Testbench for spec_acc_sched: scenario tasks against a run-level reference model.
// Latency: n/a.
// Backpressure: exercises frame_ready_i stalls and delayed dump_ack_i.
module tb_spec_acc_sched;

    localparam int FFT_LEN = 1024;
    localparam int IDX_W   = 10;
    localparam int GATE_W  = 4;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              trig;
    logic [CNT_W-1:0]  cfg_acc_num;
    logic [GATE_W-1:0] cfg_gate_last;
    logic              frame_ready;
    logic              fft_start;
    logic              spec_valid;
    logic [IDX_W-1:0]  spec_index;
    logic              acc_en;
    logic              acc_clear;
    logic [GATE_W-1:0] gate;
    logic              dump_req;
    logic              dump_ack;
    logic              done;
    logic              busy;
    logic              index_err;
    logic [CNT_W-1:0]  trig_miss;

    int errors = 0;
    int checks = 0;

    // Observations gathered by the monitor
    int n_start, n_beat, n_clear, clear_late, bad_rdy, n_done;
    bit saw_nonclear;
    int gates_q[$];

    always #5 clk = ~clk;

    spec_acc_sched #(
        .FFT_LEN (FFT_LEN), .IDX_W (IDX_W), .GATE_W (GATE_W), .CNT_W (CNT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .trig_i          (trig),
        .cfg_acc_num_i   (cfg_acc_num),
        .cfg_gate_last_i (cfg_gate_last),
        .frame_ready_i   (frame_ready),
        .fft_start_o     (fft_start),
        .spec_valid_i    (spec_valid),
        .spec_index_i    (spec_index),
        .acc_en_o        (acc_en),
        .acc_clear_o     (acc_clear),
        .gate_o          (gate),
        .dump_req_o      (dump_req),
        .dump_ack_i      (dump_ack),
        .done_o          (done),
        .busy_o          (busy),
        .index_err_o     (index_err),
        .trig_miss_o     (trig_miss)
    );

    // Sample outputs mid-cycle, well away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (fft_start) begin
                n_start++;
                gates_q.push_back(int'(gate));
                if (!frame_ready) bad_rdy++;
            end
            if (acc_en) begin
                n_beat++;
                if (acc_clear) begin
                    n_clear++;
                    if (saw_nonclear) clear_late++;
                end else begin
                    saw_nonclear = 1'b1;
                end
            end
            if (done) n_done++;
        end
    end

    task automatic mon_clear();
        n_start = 0; n_beat = 0; n_clear = 0; clear_late = 0; bad_rdy = 0; n_done = 0;
        saw_nonclear = 1'b0;
        gates_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame k of a run visits range gate k mod (gate_last+1)
    function automatic int gate_mismatches(input int gl);
        int bad = 0;
        foreach (gates_q[k]) if (gates_q[k] != k % (gl + 1)) bad++;
        return bad;
    endfunction

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (fft_start) begin ok = 1'b1; break; end
        end
        step();
    endtask

    // Drive one full run: n pulses, gl+1 gates; optional index fault and stray triggers
    task automatic drive_run(input int n, input int gl, input int rdy_low, input bit gaps,
                             input int err_frame, input int err_bin,
                             input bit trig_c, input bit trig_d,
                             output bit err_at_dump, output bit done_ok);
        bit ok;
        bit req_at_ack, done1, req_after, done2;
        int frame = 0;
        err_at_dump = 1'b0;
        done_ok = 1'b0;
        cfg_acc_num = CNT_W'(n);
        cfg_gate_last = GATE_W'(gl);
        trig = 1'b1; step(); trig = 1'b0;
        for (int p = 0; p < n; p++) begin
            for (int g = 0; g <= gl; g++) begin
                if (rdy_low > 0) begin
                    frame_ready = 1'b0;
                    repeat (rdy_low) step();
                end
                frame_ready = 1'b1;
                wait_start(ok);
                if (!ok) begin
                    checks++; errors++;
                    $display("FAIL fft_start_timeout got=0 want=1 frame=%0d", frame);
                    return;
                end
                for (int b = 0; b < FFT_LEN; b++) begin
                    if (gaps && $urandom_range(0, 7) == 0) begin
                        spec_valid = 1'b0;
                        spec_index = IDX_W'($urandom);
                        repeat ($urandom_range(1, 2)) step();
                    end
                    spec_valid = 1'b1;
                    spec_index = (frame == err_frame && b == err_bin) ? IDX_W'(b + 1) : IDX_W'(b);
                    trig = trig_c && frame == 0 && b == 500;
                    step();
                    trig = 1'b0;
                end
                spec_valid = 1'b0;
                frame++;
                if (g == gl && p < n - 1) begin
                    // stray beat while waiting for the next pulse must be ignored
                    spec_valid = 1'b1;
                    spec_index = IDX_W'($urandom);
                    step();
                    spec_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) step();
                    trig = 1'b1; step(); trig = 1'b0;
                end
            end
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dump_req) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL dump_req_timeout got=0 want=1");
            return;
        end
        err_at_dump = index_err;
        step();
        repeat ($urandom_range(0, 3)) step();
        dump_ack = 1'b1;
        trig = trig_d;
        @(negedge clk);
        req_at_ack = dump_req;
        step();
        dump_ack = 1'b0;
        trig = 1'b0;
        done1 = done;
        req_after = dump_req;
        step();
        done2 = done;
        done_ok = req_at_ack && done1 && !req_after && !done2 && !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trig = 1'b1; frame_ready = 1'b1; spec_valid = 1'b1; dump_ack = 1'b1;
        spec_index = '0; cfg_acc_num = 16'd3; cfg_gate_last = '0;
        repeat (3) step();
        checks++;
        if ({fft_start, acc_en, acc_clear, dump_req, done, busy, index_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", {fft_start, acc_en, acc_clear, dump_req, done, busy, index_err});
        end
        checks++;
        if (gate !== '0 || trig_miss !== '0) begin
            errors++;
            $display("FAIL reset_counters got gate=%0d miss=%0d want=0", gate, trig_miss);
        end
        trig = 1'b0; frame_ready = 1'b0; spec_valid = 1'b0; dump_ack = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_two_pulse();
        bit ed, dok;
        mon_clear();
        drive_run(2, 0, 0, 1'b0, -1, 0, 1'b0, 1'b0, ed, dok);
        checks++;
        if (n_start != 2) begin errors++; $display("FAIL two_pulse_starts got=%0d want=2", n_start); end
        checks++;
        if (n_beat != 2 * FFT_LEN) begin errors++; $display("FAIL two_pulse_beats got=%0d want=%0d", n_beat, 2 * FFT_LEN); end
        checks++;
        if (n_clear != FFT_LEN || clear_late != 0) begin
            errors++; $display("FAIL two_pulse_clear got=%0d late=%0d want=%0d late=0", n_clear, clear_late, FFT_LEN);
        end
        checks++;
        if (!dok || n_done != 1) begin errors++; $display("FAIL two_pulse_done got ok=%0d n=%0d want ok=1 n=1", dok, n_done); end
    endtask

    task automatic test_gates();
        bit ed, dok;
        mon_clear();
        drive_run(1, 2, 10, 1'b0, -1, 0, 1'b0, 1'b0, ed, dok);
        checks++;
        if (n_start != 3 || gate_mismatches(2) != 0) begin
            errors++; $display("FAIL gates_seq got starts=%0d bad=%0d want starts=3 bad=0", n_start, gate_mismatches(2));
        end
        checks++;
        if (bad_rdy != 0) begin errors++; $display("FAIL gates_frame_ready got=%0d want=0", bad_rdy); end
        checks++;
        if (n_beat != 3 * FFT_LEN || n_clear != 3 * FFT_LEN) begin
            errors++; $display("FAIL gates_beats got=%0d clear=%0d want=%0d", n_beat, n_clear, 3 * FFT_LEN);
        end
        checks++;
        if (!dok) begin errors++; $display("FAIL gates_done got=0 want=1"); end
    endtask

    task automatic test_trig_miss();
        bit ed, dok;
        mon_clear();
        drive_run(1, 0, 0, 1'b0, -1, 0, 1'b1, 1'b1, ed, dok);
        checks++;
        if (trig_miss !== 16'd2) begin errors++; $display("FAIL trig_miss_count got=%0d want=2", trig_miss); end
        checks++;
        if (n_start != 1 || !dok || busy) begin
            errors++; $display("FAIL trig_miss_run got starts=%0d ok=%0d busy=%0d want 1 1 0", n_start, dok, busy);
        end
    endtask

    task automatic test_index_err();
        bit ed, dok;
        mon_clear();
        drive_run(1, 0, 0, 1'b0, 0, 4, 1'b0, 1'b0, ed, dok);
        checks++;
        if (ed !== 1'b1 || index_err !== 1'b1) begin
            errors++; $display("FAIL index_err_set got dump=%0d idle=%0d want 1 1", ed, index_err);
        end
        checks++;
        if (trig_miss !== '0 || n_beat != FFT_LEN) begin
            errors++; $display("FAIL index_err_count got miss=%0d beats=%0d want 0 %0d", trig_miss, n_beat, FFT_LEN);
        end
        mon_clear();
        drive_run(1, 0, 0, 1'b0, -1, 0, 1'b0, 1'b0, ed, dok);
        checks++;
        if (ed !== 1'b0 || !dok) begin errors++; $display("FAIL index_err_clear got=%0d want=0", ed); end
    endtask

    task automatic test_reset_mid();
        bit ok, ed, dok;
        mon_clear();
        cfg_acc_num = 16'd2; cfg_gate_last = '0;
        trig = 1'b1; step(); trig = 1'b0;
        frame_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            wait_start(ok);
            for (int b = 0; b < (p == 0 ? FFT_LEN : 300); b++) begin
                spec_valid = 1'b1; spec_index = IDX_W'(b);
                trig = (b == 10);
                step();
                trig = 1'b0;
            end
            if (p == 0) begin
                spec_valid = 1'b0;
                trig = 1'b1; step(); trig = 1'b0;
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({fft_start, acc_en, acc_clear, dump_req, done, busy, index_err} !== 7'b0) begin
            errors++; $display("FAIL reset_mid_outputs got=%b want=0", {fft_start, acc_en, acc_clear, dump_req, done, busy, index_err});
        end
        checks++;
        if (trig_miss !== '0 || gate !== '0) begin
            errors++; $display("FAIL reset_mid_counters got miss=%0d gate=%0d want 0 0", trig_miss, gate);
        end
        step();
        spec_valid = 1'b0;
        rst = 1'b0;
        step();
        mon_clear();
        drive_run(1, 0, 0, 1'b0, -1, 0, 1'b0, 1'b0, ed, dok);
        checks++;
        if (n_start != 1 || n_clear != FFT_LEN || clear_late != 0 || ed || !dok) begin
            errors++; $display("FAIL reset_mid_clean got starts=%0d clear=%0d err=%0d want 1 %0d 0", n_start, n_clear, ed, FFT_LEN);
        end
    endtask

    task automatic test_disabled();
        mon_clear();
        cfg_acc_num = '0;
        frame_ready = 1'b1;
        trig = 1'b1; step(); trig = 1'b0;
        repeat (5) step();
        checks++;
        if (busy !== 1'b0 || trig_miss !== '0 || n_start != 0) begin
            errors++; $display("FAIL disabled got busy=%0d miss=%0d starts=%0d want 0 0 0", busy, trig_miss, n_start);
        end
    endtask

    task automatic test_random();
        bit ed, dok;
        for (int it = 0; it < 2; it++) begin
            int n  = $urandom_range(1, 2);
            int gl = $urandom_range(0, 2);
            bit tc = 1'($urandom_range(0, 1));
            bit td = 1'($urandom_range(0, 1));
            int g_n = gl + 1;
            mon_clear();
            drive_run(n, gl, $urandom_range(0, 5), 1'b1, -1, 0, tc, td, ed, dok);
            checks++;
            if (n_start != n * g_n || gate_mismatches(gl) != 0) begin
                errors++; $display("FAIL rand_starts got=%0d want=%0d n=%0d gl=%0d", n_start, n * g_n, n, gl);
            end
            checks++;
            if (n_beat != n * g_n * FFT_LEN || n_clear != g_n * FFT_LEN || clear_late != 0) begin
                errors++; $display("FAIL rand_beats got=%0d clear=%0d want=%0d clear=%0d", n_beat, n_clear, n * g_n * FFT_LEN, g_n * FFT_LEN);
            end
            checks++;
            if (int'(trig_miss) != int'(tc) + int'(td) || !dok || ed) begin
                errors++; $display("FAIL rand_miss_done got miss=%0d ok=%0d want miss=%0d ok=1", trig_miss, dok, int'(tc) + int'(td));
            end
        end
    endtask

    initial begin
        mon_clear();
        test_reset();
        test_two_pulse();
        test_gates();
        test_trig_miss();
        test_index_err();
        test_reset_mid();
        test_disabled();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
